// File: rtl/bcd_display_scanner.sv
// Multi-digit BCD event counter with a time-multiplexed digit scan for a 7-segment decoder.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [3:0]        o_bcd,
  output logic [DIGITS-1:0] o_digit_n,
  output logic              o_ovf
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [DIGITS-1:0][3:0] cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [PW-1:0]          pre_q, pre_d;
  logic [3:0]             bcd_q, bcd_d;
  logic [DIGITS-1:0]      dig_n_q, dig_n_d;
  logic                   ovf_q, ovf_d;
  logic                   carry;

  // Ripple carry through all digits in one cycle; carry out of the top digit is the wrap.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    carry = i_inc;
    if (i_clr) begin
      cnt_d = '0;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        if (carry) begin
          if (cnt_q[k] == 4'd9) begin
            cnt_d[k] = 4'd0;
          end else begin
            cnt_d[k] = cnt_q[k] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
      ovf_d = carry;
    end
  end

  always_comb begin
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic hi_zero, blank;
  always_comb begin
    bcd_d   = 4'd0;
    hi_zero = 1'b1;
    blank   = 1'b0;
    // Walk from the MSD down so hi_zero covers this digit and everything above it.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero & (cnt_q[k] == 4'd0);
      if (idx_q == IW'(k)) begin
        bcd_d = cnt_q[k];
        blank = hi_zero && (k != 0);
      end
    end
    dig_n_d = blank ? '1 : ~(DIGITS'(1) << idx_q);
  end
`else
  always_comb begin
    bcd_d = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) bcd_d = cnt_q[k];
    end
    dig_n_d = ~(DIGITS'(1) << idx_q);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      pre_q   <= '0;
      bcd_q   <= 4'd0;
      dig_n_q <= '1;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      bcd_q   <= bcd_d;
      dig_n_q <= dig_n_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_bcd     = bcd_q;
  assign o_digit_n = dig_n_q;
  assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed self-checking bench for bcd_display_scanner (DIGITS=4, SCAN_DIV=4).
module tb_bcd_display_scanner;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc   = 1'b1;
  logic       clr   = 1'b0;
  logic [3:0] bcd;
  logic [3:0] dn;
  logic       ovf;

  int errs   = 0;
  int checks = 0;

  logic [3:0] vals [4];
  int         nblank, nbad;

  bcd_display_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inc(inc), .i_clr(clr),
    .o_bcd(bcd), .o_digit_n(dn), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input int n);
    inc = 1'b1;
    repeat (n) tick();
    inc = 1'b0;
  endtask

  // One full scan pass with inputs idle; records the digit seen in each lit slot.
  task automatic capture();
    int s;
    for (int i = 0; i < 4; i++) vals[i] = 4'hF;
    nblank = 0;
    nbad   = 0;
    tick();
    repeat (4 * SCAN_DIV) begin
      tick();
      s = -1;
      case (dn)
        4'b1110: s = 0;
        4'b1101: s = 1;
        4'b1011: s = 2;
        4'b0111: s = 3;
        4'b1111: nblank++;
        default: nbad++;
      endcase
      if (s >= 0) vals[s] = bcd;
      if (bcd > 4'd9) nbad++;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (bcd !== 4'd0) begin errs++; $display("FAIL reset_bcd: got %0d want 0", bcd); end
    checks++; if (dn !== 4'b1111) begin errs++; $display("FAIL reset_digit_n: got %b want 1111", dn); end
    checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst_n = 1'b1;
    inc   = 1'b0;
    tick();
    checks++; if (dn !== 4'b1110) begin errs++; $display("FAIL release_digit_n: got %b want 1110", dn); end
    checks++; if (bcd !== 4'd0) begin errs++; $display("FAIL release_bcd: got %0d want 0", bcd); end
  endtask

  task automatic test_carry();
    logic [3:0] cur, prev;
    int t, len;
    pulse_inc(999);
    capture();
    checks++; if ({vals[2], vals[1], vals[0]} !== 12'h999)
      begin errs++; $display("FAIL preload_0999: got %h want 999", {vals[2], vals[1], vals[0]}); end
    pulse_inc(1);
    capture();
    checks++; if ({vals[3], vals[2], vals[1], vals[0]} !== 16'h1000)
      begin errs++; $display("FAIL carry_1000: got %h want 1000", {vals[3], vals[2], vals[1], vals[0]}); end
    checks++; if (nblank + nbad !== 0) begin errs++; $display("FAIL carry_slots: got %0d odd slots want 0", nblank + nbad); end
    prev = dn;
    t = 0;
    while (dn === prev && t < 8) begin tick(); t++; end
    checks++; if (t >= 8) begin errs++; $display("FAIL scan_advance: got no slot change want change within 8"); end
    for (int r = 0; r < 4; r++) begin
      cur = dn;
      len = 1;
      tick();
      while (dn === cur && len < 12) begin len++; tick(); end
      checks++; if (len !== SCAN_DIV) begin errs++; $display("FAIL slot_len_%0d: got %0d want %0d", r, len, SCAN_DIV); end
    end
  endtask

  task automatic test_wrap();
    int npulse;
    pulse_inc(8999);
    capture();
    checks++; if ({vals[3], vals[2], vals[1], vals[0]} !== 16'h9999)
      begin errs++; $display("FAIL preload_9999: got %h want 9999", {vals[3], vals[2], vals[1], vals[0]}); end
    inc = 1'b1;
    tick();
    inc = 1'b0;
    checks++; if (ovf !== 1'b1) begin errs++; $display("FAIL wrap_ovf: got %b want 1", ovf); end
    tick();
    checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL wrap_ovf_drop: got %b want 0", ovf); end
    capture();
    checks++; if (vals[0] !== 4'd0) begin errs++; $display("FAIL wrap_count: got %0d want 0", vals[0]); end
    // 0 -> 9998 -> 9999 -> 0 (one wrap) -> 3
    npulse = 0;
    inc = 1'b1;
    repeat (10003) begin tick(); if (ovf) npulse++; end
    inc = 1'b0;
    checks++; if (npulse !== 1) begin errs++; $display("FAIL held_inc_pulses: got %0d want 1", npulse); end
    capture();
    checks++; if (vals[0] !== 4'd3) begin errs++; $display("FAIL held_inc_count: got %0d want 3", vals[0]); end
  endtask

  task automatic test_clear_priority();
    clr = 1'b1; tick(); clr = 1'b0;
    pulse_inc(42);
    capture();
    checks++; if ({vals[1], vals[0]} !== 8'h42) begin errs++; $display("FAIL preload_0042: got %h want 42", {vals[1], vals[0]}); end
    clr = 1'b1;
    inc = 1'b1;
    tick();
    clr = 1'b0;
    inc = 1'b0;
    checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL clr_ovf: got %b want 0", ovf); end
    capture();
`ifdef LEADING_ZERO_BLANK_EN
    checks++; if (vals[0] !== 4'd0) begin errs++; $display("FAIL clr_count: got %0d want 0", vals[0]); end
    checks++; if (nblank !== 12) begin errs++; $display("FAIL clr_blank: got %0d want 12", nblank); end
`else
    checks++; if ({vals[3], vals[2], vals[1], vals[0]} !== 16'h0000)
      begin errs++; $display("FAIL clr_count: got %h want 0000", {vals[3], vals[2], vals[1], vals[0]}); end
    checks++; if (nblank !== 0) begin errs++; $display("FAIL clr_blank: got %0d want 0", nblank); end
`endif
  endtask

  task automatic test_blanking();
    clr = 1'b1; tick(); clr = 1'b0;
    pulse_inc(7);
    capture();
    checks++; if (nbad !== 0) begin errs++; $display("FAIL blank7_bad: got %0d want 0", nbad); end
`ifdef LEADING_ZERO_BLANK_EN
    checks++; if (vals[0] !== 4'd7) begin errs++; $display("FAIL blank7_val: got %0d want 7", vals[0]); end
    checks++; if (nblank !== 12) begin errs++; $display("FAIL blank7_dark: got %0d want 12", nblank); end
`else
    checks++; if ({vals[3], vals[2], vals[1], vals[0]} !== 16'h0007)
      begin errs++; $display("FAIL blank7_val: got %h want 0007", {vals[3], vals[2], vals[1], vals[0]}); end
    checks++; if (nblank !== 0) begin errs++; $display("FAIL blank7_dark: got %0d want 0", nblank); end
`endif
    clr = 1'b1; tick(); clr = 1'b0;
    pulse_inc(100);
    capture();
`ifdef LEADING_ZERO_BLANK_EN
    checks++; if ({vals[2], vals[1], vals[0]} !== 12'h100)
      begin errs++; $display("FAIL blank100_val: got %h want 100", {vals[2], vals[1], vals[0]}); end
    checks++; if (nblank !== 4) begin errs++; $display("FAIL blank100_dark: got %0d want 4", nblank); end
`else
    checks++; if ({vals[3], vals[2], vals[1], vals[0]} !== 16'h0100)
      begin errs++; $display("FAIL blank100_val: got %h want 0100", {vals[3], vals[2], vals[1], vals[0]}); end
    checks++; if (nblank !== 0) begin errs++; $display("FAIL blank100_dark: got %0d want 0", nblank); end
`endif
  endtask

  task automatic test_reset_mid_scan();
    int t, len;
    clr = 1'b1; tick(); clr = 1'b0;
    pulse_inc(9999);
    t = 0;
    while (dn !== 4'b1011 && t < 20) begin tick(); t++; end
    checks++; if (t >= 20) begin errs++; $display("FAIL find_slot2: got %b want 1011 within 20", dn); end
    // Reset lands on the same edge that would have wrapped 9999 -> 0000.
    rst_n = 1'b0;
    inc   = 1'b1;
    tick();
    checks++; if (dn !== 4'b1111) begin errs++; $display("FAIL midrst_digit_n: got %b want 1111", dn); end
    checks++; if (bcd !== 4'd0) begin errs++; $display("FAIL midrst_bcd: got %0d want 0", bcd); end
    checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
    rst_n = 1'b1;
    inc   = 1'b0;
    tick();
    checks++; if (dn !== 4'b1110) begin errs++; $display("FAIL rescan_slot0: got %b want 1110", dn); end
    checks++; if (bcd !== 4'd0) begin errs++; $display("FAIL rescan_bcd: got %0d want 0", bcd); end
    len = 1;
    tick();
    while (dn === 4'b1110 && len < 12) begin len++; tick(); end
    checks++; if (len !== SCAN_DIV) begin errs++; $display("FAIL rescan_len: got %0d want %0d", len, SCAN_DIV); end
`ifdef LEADING_ZERO_BLANK_EN
    checks++; if (dn !== 4'b1111) begin errs++; $display("FAIL rescan_next: got %b want 1111", dn); end
`else
    checks++; if (dn !== 4'b1101) begin errs++; $display("FAIL rescan_next: got %b want 1101", dn); end
`endif
  endtask

  initial begin
    test_reset();
    test_carry();
    test_wrap();
    test_clear_priority();
    test_blanking();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
